// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_rca4.sv
// Combinational 4-bit ripple-carry stage built from full-adder cells.
// Also exposes the carry into bit 3 so the caller can form signed overflow.
module nibble_rca4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co,
    output logic                c3
);

    logic [NIBBLE_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[NIBBLE_W];
    assign c3 = c[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-precision adder: one 4-bit ripple stage reused NIB times, with a
// registered carry linking consecutive nibbles. Valid/ready on both sides.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int IW  = $clog2(NIB);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;

    logic [NIBBLE_W-1:0] st_a;
    logic [NIBBLE_W-1:0] st_b;
    logic [NIBBLE_W-1:0] st_s;
    logic                st_co;
    logic                st_c3;

    // Current nibble of the latched operands feeds the single adder stage.
    assign st_a = a_r[idx*NIBBLE_W +: NIBBLE_W];
    assign st_b = b_r[idx*NIBBLE_W +: NIBBLE_W];

    nibble_rca4 u_rca (
        .a  (st_a),
        .b  (st_b),
        .ci (carry),
        .s  (st_s),
        .co (st_co),
        .c3 (st_c3)
    );

    // Handshake flags are pure decodes of the registered state.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // FSM: accept operands, ripple one nibble per cycle, hold result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= cin;
                        sum   <= '0;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[idx*NIBBLE_W +: NIBBLE_W] <= st_s;
                    carry <= st_co;
                    idx   <= idx + 1'b1;
                    if (idx == IW'(NIB-1)) begin
                        cout  <= st_co;
                        ovf   <= st_c3 ^ st_co;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: directed corner cases plus random operands against a
// plain-arithmetic reference (a+b+cin, sign-rule overflow).
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result for a+b+cin.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                         output logic [W-1:0] es, output logic ec, output logic eo);
        logic [W:0] full;
        full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        es = full[W-1:0];
        ec = full[W];
        eo = (ma[W-1] == mb[W-1]) && (es[W-1] != ma[W-1]);
    endtask

    // Present an operand pair, wait for acceptance, then wait for the result
    // and compare it. With scramble set, a/b/cin and out_ready are randomized
    // while the block is busy.
    task automatic issue(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input bit scramble);
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        int           wait_n;
        int           lat;
        model(ia, ib, ic, es, ec, eo);
        a = ia; b = ib; cin = ic; in_valid = 1'b1;
        wait_n = 0;
        while (!in_ready && wait_n < 20) begin
            step();
            wait_n++;
        end
        check({tag, "_accept_ready"}, {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (scramble) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                out_ready = 1'($urandom);
            end
            step();
            lat++;
        end
        out_ready = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(NIB));
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    // Hand the result to the consumer and confirm the return to idle.
    task automatic release_result(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        step();

        issue("basic", 16'h1234, 16'h4321, 1'b0, 1'b0);
        check("basic_const_sum", {16'd0, sum}, 32'h5555);
        release_result("basic");

        issue("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        check("ripple_const_sum", {16'd0, sum}, 32'h0000);
        release_result("ripple");

        issue("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        check("ovf_pos_const", {15'd0, ovf, sum}, 32'h1_8000);
        release_result("ovf_pos");

        issue("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0);
        check("ovf_neg_const", {14'd0, cout, ovf, sum}, 32'h3_0000);
        release_result("ovf_neg");

        // Backpressure: result held while the next pair waits at the input.
        issue("bp_first", 16'hABCD, 16'h1111, 1'b1, 1'b0);
        a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_sum", {16'd0, sum}, 32'hBCDF);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        check("bp_no_accept", {31'd0, busy}, 32'd0);
        issue("bp_second", 16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        release_result("bp_second");

        // Reset two RUN cycles into a long carry chain.
        a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("midrst_sum", {16'd0, sum}, 32'd0);
        check("midrst_cout", {31'd0, cout}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        step();
        rst = 1'b0;
        step();
        issue("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0);
        check("post_rst_const", {15'd0, cout, sum}, 32'h0002);
        release_result("post_rst");

        // Random operands with inputs and out_ready scrambled while busy.
        for (int i = 0; i < 12; i++) begin
            issue("rand", W'($urandom), W'($urandom), 1'($urandom), 1'b1);
            release_result("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-precision adder that adds two WIDTH-bit operands 4 bits per clock through one 4-bit ripple-carry stage.
- A registered carry links each nibble to the next.
- Sits between an operand source (valid/ready) and a result consumer (valid/ready). It serves datapaths wider than one 4-bit adder without widening the combinational carry chain.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair a/b/cin valid
- in_ready  output  1  block can accept an operand pair
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- cin  input  1  carry-in to nibble 0
- out_valid  output  1  sum/cout/ovf valid
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  a+b+cin mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst=1): state=IDLE, nibble index=0, carry reg=0, operand regs=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1.
- The FSM has three states: IDLE, RUN and DONE. in_ready is 1 only in IDLE and is decoded from state alone. out_valid is 1 only in DONE.
- IDLE:
  - On in_valid&&in_ready, latch a, b and cin (cin goes into the carry reg).
  - Clear the sum reg and the index, then go to RUN.
  - Otherwise hold. sum/cout/ovf keep the last result.
- RUN, cycle k (k=0..NIB-1):
  - The 4-bit stage adds a[4k+3:4k] + b[4k+3:4k] + carry reg.
  - Write the stage sum into sum[4k+3:4k]. Stage carry-out goes to the carry reg. Increment the index.
  - On k=NIB-1: cout = stage carry-out, ovf = carry into bit 3 of the stage XOR stage carry-out, then go to DONE.
  - sum shows partial nibbles during RUN. Only the value while out_valid=1 is architecturally defined.
- DONE:
  - Hold sum/cout/ovf stable.
  - On out_ready=1, go to IDLE. No new operand is accepted in the same cycle.
- Latency and throughput:
  - Accept edge at cycle 0. out_valid rises after the edge ending cycle NIB, i.e. NIB cycles after acceptance.
  - Minimum period between accepts is NIB+2 cycles.
- Boundaries:
  - Full carry propagation across all nibbles, e.g. 0xFFFF+0+1, must complete in exactly NIB RUN cycles with no extra stall.
  - in_valid asserted in RUN or DONE is ignored. The source must hold it, and it is accepted on the first IDLE cycle.
  - out_ready asserted outside DONE has no effect.
  - rst mid-RUN or mid-DONE aborts immediately: all outputs go to reset values, no stale carry survives, and the partial result is discarded.
  - Operand inputs are sampled only at the accept edge, so later changes on a/b/cin do not affect the result.

Decomposition:
- Shared package: FSM state enum (IDLE, RUN, DONE) and NIBBLE_W=4 constant.
- Sub-module nibble_rca4: combinational 4-bit ripple-carry stage built from full-adder cells. It exposes sum[3:0], carry-out and carry into bit 3 (for ovf).
- The top level holds the FSM, index counter, carry reg, operand regs and result reg.

Test Plan (WIDTH=16, NIB=4):
- Basic add: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge.
- Full carry ripple: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0, same 4-cycle latency.
- Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid with next in_valid held high.
  - Required: sum/cout/ovf stable, in_ready=0, no accept.
  - After out_ready pulses, the block is in IDLE next cycle and accepts the waiting pair.
- Reset mid-operation: assert rst after 2 RUN cycles of 0xFFFF+0x0001.
  - Required: outputs go to 0 and in_ready=1 immediately.
  - Then 0x0001+0x0001, cin=0 -> sum=0x0002, cout=0 (no stale carry).
- Input isolation: change a/b every cycle during RUN -> result matches the operands latched at the accept edge.
